// File: rtl/hilo_muldiv_pkg.sv
// Shared operation and FSM encodings for hilo_muldiv, plus a two's-complement helper
// used for the magnitude-based signed multiply/divide.
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NOP2  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  function automatic logic [31:0] condNeg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] condNeg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Radix-2 restoring divider datapath for hilo_muldiv: unsigned magnitudes only,
// one quotient bit per step, with a 6-bit iteration counter.
module div_iter
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        last_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Outputs are the next-state values so the top can capture the final result on the last step edge.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo_o  = quo_d;
  assign rem_o  = rem_d;
  assign last_o = (cnt_q == 6'd31);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: iterative divide, MTHI/MTLO, and multiply that is
// single-cycle when MULDIV_FAST_MUL_EN is defined, else 32-step shift-add.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        wehi,
  output logic        welo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  op_e         opIn;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        wehi_q, wehi_d, welo_q, welo_d;
  logic        negQ_q, negQ_d, negR_q, negR_d, divZero_q, divZero_d;
  logic        isSigned, divLoad, divStep, divLast;
  logic [31:0] aMag, bMag, quoNext, remNext;

  assign opIn     = op_e'(op);
  assign isSigned = (opIn == OP_MULT) || (opIn == OP_DIV);
  assign aMag     = condNeg32(a, isSigned & a[31]);
  assign bMag     = condNeg32(b, isSigned & b[31]);

  div_iter u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (divLoad),
    .step_i     (divStep),
    .dividend_i (aMag),
    .divisor_i  (bMag),
    .quo_o      (quoNext),
    .rem_o      (remNext),
    .last_o     (divLast)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fastProd;
  assign fastProd = {{32{isSigned & a[31]}}, a} * {{32{isSigned & b[31]}}, b};
`else
  logic [63:0] mulProd_q, mulProd_d, mulStep;
  logic [31:0] mulCand_q, mulCand_d;
  logic [32:0] mulSum;

  // Shift-add: low half holds the remaining multiplier bits, high half accumulates.
  assign mulSum  = {1'b0, mulProd_q[63:32]} + (mulProd_q[0] ? {1'b0, mulCand_q} : 33'd0);
  assign mulStep = {mulSum, mulProd_q[31:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mulProd_q <= '0;
      mulCand_q <= '0;
    end else begin
      mulProd_q <= mulProd_d;
      mulCand_q <= mulCand_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wehi_d    = 1'b0;
    welo_d    = 1'b0;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    divZero_d = divZero_q;
    divLoad   = 1'b0;
    divStep   = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
    mulProd_d = mulProd_q;
    mulCand_d = mulCand_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (opIn)
            OP_MTHI: begin
              hi_d   = a;
              wehi_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              welo_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = fastProd;
              wehi_d       = 1'b1;
              welo_d       = 1'b1;
`else
              state_d   = MUL;
              divLoad   = 1'b1;
              negQ_d    = isSigned & (a[31] ^ b[31]);
              mulProd_d = {32'd0, bMag};
              mulCand_d = aMag;
`endif
            end
            OP_DIV, OP_DIVU: begin
              state_d   = DIV;
              divLoad   = 1'b1;
              negQ_d    = isSigned & (a[31] ^ b[31]);
              negR_d    = isSigned & a[31];
              divZero_d = (b == 32'd0);
            end
            default: ;
          endcase
        end
      end
      MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        state_d = IDLE;
`else
        divStep   = 1'b1;
        mulProd_d = mulStep;
        if (divLast) begin
          state_d      = DONE;
          {hi_d, lo_d} = condNeg64(mulStep, negQ_q);
          wehi_d       = 1'b1;
          welo_d       = 1'b1;
        end
`endif
      end
      DIV: begin
        divStep = 1'b1;
        if (divLast) begin
          state_d = DONE;
          // Remainder of |a|/0 is |a|, so sign fixup alone restores hi=a on divide by zero.
          lo_d    = divZero_q ? DIV_ZERO_QUO : condNeg32(quoNext, negQ_q);
          hi_d    = condNeg32(remNext, negR_q);
          wehi_d  = 1'b1;
          welo_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      wehi_d  = 1'b0;
      welo_d  = 1'b0;
      divLoad = 1'b0;
      divStep = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      wehi_q    <= 1'b0;
      welo_q    <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wehi_q    <= wehi_d;
      welo_q    <= welo_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign wehi = wehi_q;
  assign welo = welo_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random ops
// against an arithmetic reference model (honours MULDIV_FAST_MUL_EN).
module tb_hilo_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, wehi, welo;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;
  logic [31:0] expHi, expLo;
  logic        expWeHi, expWeLo;
  int          expLat;

  hilo_muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .wehi  (wehi),
    .welo  (welo),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: plain arithmetic on the architectural HI/LO pair.
  task automatic predict(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] up;
    expHi = modelHi; expLo = modelLo; expWeHi = 1'b0; expWeLo = 1'b0; expLat = 0;
    case (o)
      3'b001: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {expHi, expLo} = sp;
        expWeHi = 1'b1; expWeLo = 1'b1; expLat = MUL_LAT;
      end
      3'b010: begin
        up = {32'd0, x} * {32'd0, y};
        {expHi, expLo} = up;
        expWeHi = 1'b1; expWeLo = 1'b1; expLat = MUL_LAT;
      end
      3'b011: begin
        if (y == 32'd0) begin
          expLo = 32'hFFFF_FFFF; expHi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          expLo = 32'h8000_0000; expHi = 32'd0;
        end else begin
          expLo = $signed(x) / $signed(y);
          expHi = $signed(x) % $signed(y);
        end
        expWeHi = 1'b1; expWeLo = 1'b1; expLat = 33;
      end
      3'b100: begin
        if (y == 32'd0) begin
          expLo = 32'hFFFF_FFFF; expHi = x;
        end else begin
          expLo = x / y; expHi = x % y;
        end
        expWeHi = 1'b1; expWeLo = 1'b1; expLat = 33;
      end
      3'b101: begin expHi = x; expWeHi = 1'b1; expLat = 1; end
      3'b110: begin expLo = x; expWeLo = 1'b1; expLat = 1; end
      default: ;
    endcase
  endtask

  // Issues one op; intrudeAt>0 drives an MTHI start at that cycle while the op is in flight.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int intrudeAt);
    int cyc, busyCnt, strikes;
    predict(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; busyCnt = 0; strikes = 0;
    if (expLat == 0) begin
      repeat (3) begin
        strikes += int'(wehi | welo);
        busyCnt += int'(busy);
        @(posedge clk); #1;
      end
      checkOutput("nopStrike", 64'(strikes), 64'd0);
      checkOutput("nopBusy", 64'(busyCnt), 64'd0);
      checkOutput("nopHiLo", {hi, lo}, {modelHi, modelLo});
      return;
    end
    while (!(wehi || welo) && cyc < 60) begin
      busyCnt += int'(busy);
      if (cyc == intrudeAt) begin
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    busyCnt += int'(busy);
    checkOutput("latency", 64'(cyc), 64'(expLat));
    checkOutput("busyCycles", 64'(busyCnt), (expLat > 1) ? 64'(expLat) : 64'd0);
    checkOutput("strikes", {62'd0, wehi, welo}, {62'd0, expWeHi, expWeLo});
    checkOutput("hi", 64'(hi), 64'(expHi));
    checkOutput("lo", 64'(lo), 64'(expLo));
    modelHi = expHi; modelLo = expLo;
    @(posedge clk); #1;
    checkOutput("afterStrike", {61'd0, busy, wehi, welo}, 64'd0);
  endtask

  initial begin
    int strikes;
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    #12;
    checkOutput("resetState", {29'd0, busy, wehi, welo, hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;

    applyStimulus(3'b100, 32'd100, 32'd7, 0);
    applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'b100, 32'd5, 32'd0, 0);
    applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b011, 32'hFFFF_FFF0, 32'd0, 0);
    applyStimulus(3'b001, 32'hFFFF_FFFE, 32'd3, 0);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b110, 32'hCAFE_F00D, 32'd0, 0);
    applyStimulus(3'b101, 32'h1234_5678, 32'd0, 0);
    applyStimulus(3'b000, 32'h1111_1111, 32'd0, 0);
    applyStimulus(3'b111, 32'h2222_2222, 32'd0, 0);
    applyStimulus(3'b100, 32'd1000, 32'd33, 5);
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 5);

    // Flush at iteration 10 with a competing start: back to IDLE, no strike, HI/LO held.
    @(negedge clk); start = 1'b1; op = 3'b011; a = 32'd12345; b = 32'd17;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1; start = 1'b1; op = 3'b101; a = 32'hAAAA_5555;
    @(posedge clk); #1; flush = 1'b0; start = 1'b0;
    checkOutput("flushIdle", {62'd0, busy, wehi | welo}, 64'd0);
    checkOutput("flushHiLo", {hi, lo}, {modelHi, modelLo});
    strikes = 0;
    repeat (40) begin @(posedge clk); #1; strikes += int'(wehi | welo); end
    checkOutput("flushNoStrike", 64'(strikes), 64'd0);
    checkOutput("flushHiLoLater", {hi, lo}, {modelHi, modelLo});

    // Reset at iteration 20: outputs clear immediately, nothing strikes afterwards.
    @(negedge clk); start = 1'b1; op = 3'b100; a = 32'd999; b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    checkOutput("rstAsync", {29'd0, busy, wehi, welo, hi, lo}, 64'd0);
    modelHi = 32'd0; modelLo = 32'd0;
    @(negedge clk); rst = 1'b0;
    strikes = 0;
    repeat (40) begin @(posedge clk); #1; strikes += int'(wehi | welo | busy); end
    checkOutput("rstNoStrike", 64'(strikes), 64'd0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
      applyStimulus(ro, ra, rb, (i % 4 == 0) ? 7 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  request to accept the operation on op/a/b.
REQ-004 SHALL have port: op  input  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
REQ-005 SHALL have port: a  input  32  operand A (dividend / multiplicand / MTHI-MTLO source).
REQ-006 SHALL have port: b  input  32  operand B (divisor / multiplier).
REQ-007 SHALL have port: flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE; the pipeline stalls on it.
REQ-009 SHALL have port: wehi  output  1  one-cycle HI write strike toward the HI/LO register.
REQ-010 SHALL have port: welo  output  1  one-cycle LO write strike.
REQ-011 SHALL have port: hi  output  32  HI write data, registered, held between strikes.
REQ-012 SHALL have port: lo  output  32  LO write data, registered, held between strikes.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-014 SHALL accept start only in IDLE with a non-NOP op; start in any other state, or with a NOP op, SHALL be ignored.
REQ-015 SHALL, for MTHI/MTLO, load hi (or lo) from a and pulse wehi (or welo) only, in the cycle after the accept edge; busy SHALL stay low.
REQ-016 SHALL, for DIV/DIVU, run a radix-2 restoring divide over 32 iteration cycles (DIV), then DONE; wehi and welo SHALL pulse together in the DONE cycle, 33 cycles after the accept edge; lo=quotient, hi=remainder.
REQ-017 SHALL, for signed ops, operate on magnitudes; a negative quotient SHALL result when operand signs differ, and the remainder sign SHALL equal the dividend sign.
REQ-018 SHALL return, for a divide by zero, lo=32'hFFFFFFFF and hi=a, with normal latency.
REQ-019 SHALL return, for DIV 32'h80000000 / 32'hFFFFFFFF, lo=32'h80000000 and hi=0.
REQ-020 SHALL produce the 64-bit product {hi,lo} for MULT (signed) and MULTU (unsigned).
REQ-021 SHALL give flush priority over every other event: from any state, flush SHALL return the FSM to IDLE at the next edge with no wehi/welo pulse, and a start in the same cycle SHALL be ignored.
REQ-022 SHALL hold hi/lo unchanged when an operation is aborted.
REQ-023 SHALL leave IDLE->IDLE on the DONE->IDLE transition, so that a new start can be accepted in the cycle after DONE.

Reset
REQ-024 SHALL, while rst is high (asynchronously), force: state IDLE, busy 0, wehi 0, welo 0, hi 0, lo 0, and clear the iteration counter and partial registers.
REQ-025 SHALL discard any operation in flight when rst is asserted mid-operation, with no write pulse after release.

Configuration
REQ-026 SHALL use the macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU SHALL use a combinational 32x32 product registered into hi/lo, strike in the cycle after accept, with busy low; when undefined, MULT/MULTU SHALL use iterative shift-add in state MUL (32 cycles) and strike 33 cycles after accept, identical to divide timing.

Structure
REQ-027 SHALL define the op encodings and the FSM state encodings in the shared defines header (defines2.vh); the module SHALL contain no local duplicates of them.
REQ-028 SHALL place the iterative divider datapath (remainder/quotient shift registers, 6-bit counter) in the sub-module div_iter; sign fixup and FSM SHALL remain in hilo_muldiv.

Verification
REQ-029 SHALL verify: DIVU a=100, b=7 -> busy for 33 cycles, then one-cycle wehi=welo=1, lo=14, hi=2.
REQ-030 SHALL verify: DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-031 SHALL verify: DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5 at 33 cycles; DIV 32'h80000000/-1 -> lo=32'h80000000, hi=0.
REQ-032 SHALL verify: MULT a=-2, b=3 -> {hi,lo}=64'hFFFFFFFF_FFFFFFFA (1 cycle with MULDIV_FAST_MUL_EN, 33 without); MULTU 32'hFFFFFFFF squared -> hi=32'hFFFFFFFE, lo=1.
REQ-033 SHALL verify: flush at iteration 10 of DIV, with start asserted in the same cycle -> IDLE next edge, no strike, hi/lo unchanged; rst at iteration 20 -> all outputs 0 immediately.
REQ-034 SHALL verify: MTHI a=32'h12345678 -> only wehi pulses, hi=32'h12345678, lo unchanged; start during busy -> ignored.
